// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the video clock PLL on the reference clock.
// Retries failed lock attempts, faults after a retry limit, gates sys_rst_n.
module pll_lock_sequencer #(
  parameter int STARTUP_CYCLES      = 50,
  parameter int LOCK_STABLE_CYCLES  = 1000,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAULT
  } state_t;

  localparam logic [CNT_W-1:0] STARTUP_LAST =
    CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST =
    CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRIES);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       retry_d;
  logic [7:0]       loss_d;
  logic             sync1, locked_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    retry_d = retry_count;
    loss_d  = lock_loss_count;
    unique case (state)
      RESET_PLL: begin
        if (cnt == STARTUP_LAST) state_d = WAIT_LOCK;
        else cnt_d = cnt + 1'b1;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_count == RETRY_MAX) begin
            state_d = FAULT;
          end else begin
            state_d = RESET_PLL;
            retry_d = retry_count + 2'd1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_d = RUN;
          retry_d = 2'd0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = RESET_PLL;
          if (lock_loss_count != 8'hFF)
            loss_d = lock_loss_count + 8'd1;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase
    // A relock request overrides everything, including a loss count
    if (force_relock && state != RESET_PLL) begin
      state_d = RESET_PLL;
      retry_d = 2'd0;
      loss_d  = lock_loss_count;
    end
    if (state_d != state) cnt_d = '0;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RESET_PLL;
      cnt             <= '0;
      retry_count     <= 2'd0;
      lock_loss_count <= 8'd0;
      pll_rst         <= 1'b1;
      sys_rst_n       <= 1'b0;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      retry_count     <= retry_d;
      lock_loss_count <= loss_d;
      pll_rst   <= (state_d == RESET_PLL) || (state_d == FAULT);
      sys_rst_n <= (state_d == RUN);
      ready     <= (state_d == RUN);
      fault     <= (state_d == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scenario bench for pll_lock_sequencer.
// Expected output vectors are queued per scenario and popped by cycle index.
module tb_pll_lock_sequencer;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          k;
    logic [13:0] v;
  } exp_t;

  exp_t q[$];
  exp_t e;

  pll_lock_sequencer #(
    .STARTUP_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(20),
    .MAX_RETRIES        (2),
    .CNT_W              (16)
  ) dut (
    .refclk         (refclk),
    .rst_n          (rst_n),
    .pll_locked     (pll_locked),
    .force_relock   (force_relock),
    .pll_rst        (pll_rst),
    .sys_rst_n      (sys_rst_n),
    .ready          (ready),
    .fault          (fault),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  // {pll_rst, sys_rst_n, ready, fault, retry_count, lock_loss_count}
  function automatic logic [13:0] ev(
    input logic pr, input logic sr, input logic rd, input logic fl,
    input logic [1:0] rc, input logic [7:0] lc);
    return {pr, sr, rd, fl, rc, lc};
  endfunction

  function automatic logic [13:0] obs();
    return {pll_rst, sys_rst_n, ready, fault,
            retry_count, lock_loss_count};
  endfunction

  function automatic logic [13:0] run_v(input logic [7:0] lc);
    return ev(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, lc);
  endfunction

  task automatic test_reset();
    q.delete();
    for (int k = 0; k <= 2; k++)
      q.push_back('{k, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    for (int k = 0; k <= 2; k++) begin
      rst_n = 1'b0;
      #1;
      while (q.size() > 0 && q[0].k == k) begin
        e = q.pop_front();
        total++;
        if (obs() !== e.v) begin
          bad++;
          $display("FAIL reset k=%0d got=%h want=%h", k, obs(), e.v);
        end
      end
      @(negedge refclk);
    end
  endtask

  task automatic test_nominal();
    q.delete();
    q.push_back('{0, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{3, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{4, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{24, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{25, run_v(8'd0)});
    for (int k = 0; k <= 25; k++) begin
      if (k == 0) rst_n = 1'b1;
      if (k == 14) pll_locked = 1'b1;
      #1;
      while (q.size() > 0 && q[0].k == k) begin
        e = q.pop_front();
        total++;
        if (obs() !== e.v) begin
          bad++;
          $display("FAIL nominal k=%0d got=%h want=%h", k, obs(), e.v);
        end
      end
      @(negedge refclk);
    end
  endtask

  task automatic test_glitch();
    q.delete();
    q.push_back('{1, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{4, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{5, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{16, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{18, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{24, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{25, run_v(8'd0)});
    for (int k = 0; k <= 25; k++) begin
      if (k == 0) begin
        force_relock = 1'b1;
        pll_locked   = 1'b0;
      end
      if (k == 1) force_relock = 1'b0;
      if (k == 7) pll_locked = 1'b1;
      if (k == 13) pll_locked = 1'b0;
      if (k == 14) pll_locked = 1'b1;
      #1;
      while (q.size() > 0 && q[0].k == k) begin
        e = q.pop_front();
        total++;
        if (obs() !== e.v) begin
          bad++;
          $display("FAIL glitch k=%0d got=%h want=%h", k, obs(), e.v);
        end
      end
      @(negedge refclk);
    end
  endtask

  task automatic test_retry_fault();
    q.delete();
    for (int a = 0; a < 3; a++) begin
      q.push_back('{24 * a + 1 - (a > 0 ? 0 : 0) + (a == 0 ? 0 : 0),
                    ev(1'b1, 1'b0, 1'b0, 1'b0, 2'(a), 8'd0)});
      q.push_back('{24 * a + 4,
                    ev(1'b1, 1'b0, 1'b0, 1'b0, 2'(a), 8'd0)});
      q.push_back('{24 * a + 5,
                    ev(1'b0, 1'b0, 1'b0, 1'b0, 2'(a), 8'd0)});
      q.push_back('{24 * a + 24,
                    ev(1'b0, 1'b0, 1'b0, 1'b0, 2'(a), 8'd0)});
    end
    q.push_back('{73, ev(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'd0)});
    q.push_back('{100, ev(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'd0)});
    for (int k = 0; k <= 100; k++) begin
      if (k == 0) begin
        force_relock = 1'b1;
        pll_locked   = 1'b0;
      end
      if (k == 1) force_relock = 1'b0;
      #1;
      while (q.size() > 0 && q[0].k == k) begin
        e = q.pop_front();
        total++;
        if (obs() !== e.v) begin
          bad++;
          $display("FAIL retry k=%0d got=%h want=%h", k, obs(), e.v);
        end
      end
      @(negedge refclk);
    end
  endtask

  task automatic test_fault_recovery();
    q.delete();
    q.push_back('{0, ev(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'd0)});
    q.push_back('{1, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{5, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{15, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{16, run_v(8'd0)});
    for (int k = 0; k <= 16; k++) begin
      if (k == 0) force_relock = 1'b1;
      if (k == 1) force_relock = 1'b0;
      if (k == 5) pll_locked = 1'b1;
      #1;
      while (q.size() > 0 && q[0].k == k) begin
        e = q.pop_front();
        total++;
        if (obs() !== e.v) begin
          bad++;
          $display("FAIL recovery k=%0d got=%h want=%h", k, obs(), e.v);
        end
      end
      @(negedge refclk);
    end
  endtask

  task automatic test_lock_loss();
    q.delete();
    q.push_back('{2, run_v(8'd0)});
    q.push_back('{3, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1)});
    q.push_back('{6, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1)});
    q.push_back('{7, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1)});
    q.push_back('{17, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1)});
    q.push_back('{18, run_v(8'd1)});
    for (int k = 0; k <= 18; k++) begin
      if (k == 0) pll_locked = 1'b0;
      if (k == 7) pll_locked = 1'b1;
      #1;
      while (q.size() > 0 && q[0].k == k) begin
        e = q.pop_front();
        total++;
        if (obs() !== e.v) begin
          bad++;
          $display("FAIL lock_loss k=%0d got=%h want=%h", k, obs(), e.v);
        end
      end
      @(negedge refclk);
    end
  endtask

  task automatic test_simultaneous();
    q.delete();
    q.push_back('{2, run_v(8'd1)});
    q.push_back('{3, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1)});
    q.push_back('{7, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1)});
    q.push_back('{18, run_v(8'd1)});
    for (int k = 0; k <= 18; k++) begin
      if (k == 0) pll_locked = 1'b0;
      if (k == 2) force_relock = 1'b1;
      if (k == 3) force_relock = 1'b0;
      if (k == 7) pll_locked = 1'b1;
      #1;
      while (q.size() > 0 && q[0].k == k) begin
        e = q.pop_front();
        total++;
        if (obs() !== e.v) begin
          bad++;
          $display("FAIL simultaneous k=%0d got=%h want=%h",
                   k, obs(), e.v);
        end
      end
      @(negedge refclk);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] lc;
    q.delete();
    for (int i = 0; i < 255; i++) begin
      lc = (i + 2 > 255) ? 8'd255 : 8'(i + 2);
      q.push_back('{18 * i + 3, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, lc)});
      q.push_back('{18 * i + 18, run_v(lc)});
    end
    for (int k = 0; k <= 18 * 255; k++) begin
      if (k % 18 == 0) pll_locked = 1'b0;
      if (k % 18 == 7) pll_locked = 1'b1;
      #1;
      while (q.size() > 0 && q[0].k == k) begin
        e = q.pop_front();
        total++;
        if (obs() !== e.v) begin
          bad++;
          $display("FAIL saturate k=%0d got=%h want=%h", k, obs(), e.v);
        end
      end
      @(negedge refclk);
    end
  endtask

  task automatic test_reset_mid_wait();
    q.delete();
    q.push_back('{4, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd255)});
    q.push_back('{7, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd255)});
    q.push_back('{8, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{9, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{13, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    q.push_back('{14, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0)});
    for (int k = 0; k <= 14; k++) begin
      if (k == 0) begin
        force_relock = 1'b1;
        pll_locked   = 1'b0;
      end
      if (k == 1) force_relock = 1'b0;
      if (k == 8) rst_n = 1'b0;
      if (k == 10) rst_n = 1'b1;
      #1;
      while (q.size() > 0 && q[0].k == k) begin
        e = q.pop_front();
        total++;
        if (obs() !== e.v) begin
          bad++;
          $display("FAIL rst_mid k=%0d got=%h want=%h", k, obs(), e.v);
        end
      end
      @(negedge refclk);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    @(negedge refclk);
    test_reset();
    test_nominal();
    test_glitch();
    test_retry_fault();
    test_fault_recovery();
    test_lock_loss();
    test_simultaneous();
    test_saturation();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
